// File: rtl/lsu_dmem_if.sv
// lsu_dmem_if: MEM-stage load/store unit driving a req/gnt/rvalid data-memory port.
// Define LSU_MISALIGN_TRAP_EN to flag misaligned H/W accesses instead of truncating them.
module lsu_dmem_if #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       st_data,
    output logic              stall,
    output logic [31:0]       ld_data,
    output logic              misalign,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_wstrb,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
    state_t      state;
    logic [2:0]  f3_q;
    logic [1:0]  a_q;
    logic        acc, sz_w, sz_h, mis;
    logic [3:0]  wstrb;
    logic [31:0] wdata, ext;
    logic [7:0]  lb;
    logic [15:0] lh;
    always_comb begin
        acc   = mem_rd | mem_wr;
        sz_w  = funct3[1];
        sz_h  = !funct3[1] && funct3[0];
        wstrb = sz_w ? 4'hf : sz_h ? (addr[1] ? 4'hc : 4'h3) : 4'b0001 << addr[1:0];
        wdata = sz_w ? st_data : sz_h ? {2{st_data[15:0]}} : {4{st_data[7:0]}};
`ifdef LSU_MISALIGN_TRAP_EN
        mis   = (sz_h && addr[0]) || (sz_w && addr[1:0] != 2'b00);
`else
        mis   = 1'b0;
`endif
        lb    = mem_rdata[{a_q, 3'b000} +: 8];
        lh    = a_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        ext   = f3_q[1] ? mem_rdata :
                f3_q[0] ? {{16{lh[15] & ~f3_q[2]}}, lh} : {{24{lb[7] & ~f3_q[2]}}, lb};
        stall = (state == IDLE && acc) || state == REQ || state == WAIT;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            f3_q      <= '0;
            a_q       <= '0;
            ld_data   <= '0;
            misalign  <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wstrb <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: if (acc) begin
                    if (mis) begin
                        misalign <= 1'b1;
                        state    <= DONE;
                    end else begin
                        mem_req   <= 1'b1;
                        mem_we    <= mem_wr;
                        mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
                        mem_wstrb <= wstrb;
                        mem_wdata <= wdata;
                        f3_q      <= funct3;
                        a_q       <= addr[1:0];
                        state     <= REQ;
                    end
                end
                REQ: if (mem_gnt) begin
                    mem_req <= 1'b0;
                    state   <= mem_we ? DONE : WAIT;
                end
                WAIT: if (mem_rvalid) begin
                    ld_data <= ext;
                    state   <= DONE;
                end
                DONE: begin
                    misalign <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/lsu_dmem_if.md
Name: lsu_dmem_if

Overview:
- Load/store unit in the MEM stage of the 5-stage pipeline.
- Issues data-memory requests over a req/gnt/rvalid handshake and stalls the pipeline until each access completes.
- Aligns and sign/zero-extends load data and presents it as ld_data. The MEM/WB register captures ld_data on the cycle the stall drops.

Parameters:
- ADDR_W, 32, byte-address width of addr and mem_addr; data width fixed at 32.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- mem_rd  in  1  MEM-stage instruction is a load
- mem_wr  in  1  MEM-stage instruction is a store; has priority over mem_rd if both are set
- funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr  in  ADDR_W  byte address (ALU result)
- st_data  in  32  store data (rs2)
- stall  out  1  hold PC and all pipeline registers up to and including EX/MEM
- ld_data  out  32  aligned, extended load result (registered)
- misalign  out  1  misaligned-access flag (see Optional Feature)
- mem_req  out  1  memory request valid
- mem_we  out  1  1 = write
- mem_addr  out  ADDR_W  word-aligned address; addr with bits [1:0] forced to 0
- mem_wstrb  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_gnt  in  1  memory accepts request this cycle
- mem_rvalid  in  1  read data valid; earliest the cycle after gnt
- mem_rdata  in  32  read word

Behaviour:
- FSM states: IDLE, REQ, WAIT, DONE. Reset puts the FSM in IDLE.
- Reset values: mem_req=0, mem_we=0, mem_addr=0, mem_wstrb=0, mem_wdata=0, ld_data=0, misalign=0, stall=0 (stall is combinational).
- stall = (IDLE & (mem_rd|mem_wr)) | REQ | WAIT. stall is 0 in DONE.
- IDLE:
  - On an access, latch mem_we/mem_addr/mem_wstrb/mem_wdata and go to REQ.
  - mem_req is registered and goes high in REQ.
- REQ:
  - mem_req=1; mem_* outputs stay stable until gnt.
  - On gnt, a store goes to DONE and a load goes to WAIT.
  - mem_req drops the cycle after gnt.
- WAIT:
  - On rvalid, capture the extended result into ld_data and go to DONE.
  - rvalid in any other state is ignored.
- DONE:
  - Lasts exactly one cycle, with stall=0 so the pipeline advances; then go to IDLE.
  - The next instruction is sampled in IDLE; the same access is never re-issued.
- Minimum latency with zero-wait memory: load 4 cycles in MEM, store 3 cycles in MEM.
- Store byte enables and data:
  - SB: wstrb = 0001 << addr[1:0], wdata = {4{st_data[7:0]}}.
  - SH: wstrb = 0011 << {addr[1],0}, wdata = {2{st_data[15:0]}}.
  - SW: wstrb = 1111, wdata = st_data.
- Load lane select:
  - Byte loads use lane addr[1:0]; half loads use half addr[1].
  - B and H sign-extend; BU and HU zero-extend; W passes the word.
- ld_data holds its value until the next load completes; stores and idle cycles do not change it.
- Without the feature, misaligned addresses are truncated: H ignores addr[0], W ignores addr[1:0].
- Reset mid-operation returns to IDLE and drops mem_req the same cycle. A later rvalid for the abandoned read is ignored.
- funct3 values 011, 110 and 111 are treated as W.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - A misaligned access (H with addr[0]=1; W with addr[1:0]!=00) issues no memory request. IDLE goes directly to DONE.
  - misalign=1 for that DONE cycle only. ld_data is unchanged for a misaligned load.
- Not defined: misalign is tied to 0 and truncation applies.

Test Plan:
- SW addr=0x104, st_data=0xDEADBEEF, gnt in first REQ cycle -> mem_addr=0x104, wstrb=1111, wdata=0xDEADBEEF, stall high for 2 cycles, low in DONE.
- SB addr=0x103, st_data=0x000000A5 -> wstrb=1000, wdata=0xA5A5A5A5, mem_we=1.
- LB addr=0x102, rdata=0x1280FF00, rvalid 3 cycles after gnt -> ld_data=0xFFFFFF80, stall held until DONE. LBU same access -> ld_data=0x00000080.
- LH addr=0x202, rdata=0x8001_7FFF -> ld_data=0xFFFF8001. LHU -> ld_data=0x00008001.
- gnt delayed 5 cycles -> mem_addr/wstrb/wdata stable throughout REQ.
- rst asserted in WAIT, then a late rvalid -> state IDLE, ld_data=0, stall=0, late rvalid ignored.
- With LSU_MISALIGN_TRAP_EN, LW addr=0x101 -> mem_req never asserts, misalign=1 for one cycle, ld_data unchanged.
